// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared mode and debounce-state encodings for the display scheduler
package display_pkg;

  typedef enum logic [1:0] {
    MODE_LED = 2'd0,
    MODE_CNT = 2'd1,
    MODE_JMP = 2'd2,
    MODE_MEM = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } deb_state_e;

  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton synchronizer and debounce FSM
// Emits a single-cycle press pulse once the button has been stably high for DEB_CYCLES.
module btn_debounce
  import display_pkg::*;
#(
  parameter int DEB_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts consecutive stable cycles spent inside a confirm state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/display_sched.sv
// rtl/display_sched.sv - 8-digit scan scheduler with frame-aligned manual/auto mode switching
module display_sched
  import display_pkg::*;
#(
  parameter int SCAN_DIV      = 40000,
  parameter int DEB_CYCLES    = 200000,
  parameter int ROTATE_FRAMES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       auto_en,
  output logic [1:0] mode,
  output logic [2:0] pos,
  output logic [7:0] an,
  output logic       scan_tick,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(ROTATE_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(ROTATE_FRAMES - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    pos_q, pos_d;
  mode_e         mode_q, mode_d;
  mode_e         tgt_q, tgt_d;
  logic          pend_q, pend_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          press, auto_req, req;
  mode_e         base;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_mode),
    .press_o(press)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      pos_q   <= '0;
      mode_q  <= MODE_LED;
      tgt_q   <= MODE_LED;
      pend_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    scan_tick  = (presc_q == PRESC_LAST);
    frame_done = scan_tick && (pos_q == 3'd7);
    presc_d    = scan_tick ? '0 : presc_q + 1'b1;
    pos_d      = scan_tick ? pos_q + 3'd1 : pos_q;

    // A press wins over a simultaneous auto request; both clear the rotation count.
    auto_req = auto_en && frame_done && (fcnt_q == FCNT_LAST) && !press;
    req      = press || auto_req;
    if (!auto_en || req) begin
      fcnt_d = '0;
    end else if (frame_done) begin
      fcnt_d = fcnt_q + 1'b1;
    end else begin
      fcnt_d = fcnt_q;
    end

    mode_d = mode_q;
    tgt_d  = tgt_q;
    pend_d = pend_q;
    base   = pend_q ? tgt_q : mode_q;
    if (frame_done && pend_q) begin
      mode_d = tgt_q;
      pend_d = 1'b0;
    end
    // A request made in the frame_done cycle stays pending for the next boundary.
    if (req) begin
      tgt_d  = next_mode(base);
      pend_d = 1'b1;
    end
  end

  assign mode = mode_q;
  assign pos  = pos_q;
  assign an   = (mode_q == MODE_CNT && pos_q[2]) ? 8'hFF : ~(8'h01 << pos_q);

endmodule

// File: doc/display_sched.md
DISPLAY_SCHED -- requirements
Module: display_sched

Interface
REQ-001 Parameter SCAN_DIV, default 40000: clk cycles per digit slot.
REQ-002 Parameter DEB_CYCLES, default 200000: clk cycles the button must be stable.
REQ-003 Parameter ROTATE_FRAMES, default 1000: full 8-digit frames per auto-rotate step.
REQ-004 clk  input  1  single system clock; all state on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 btn_mode  input  1  raw asynchronous pushbutton, active-high.
REQ-007 auto_en  input  1  level; 1 enables automatic mode rotation.
REQ-008 mode  output  2  display source select: 0 leddata, 1 totaltimes, 2 JMP/CJMP, 3 mem.
REQ-009 pos  output  3  current digit index, 0 = rightmost.
REQ-010 an  output  8  active-low one-hot anode enable.
REQ-011 scan_tick  output  1  one-cycle pulse per digit-slot advance.
REQ-012 frame_done  output  1  one-cycle pulse when pos wraps 7->0.

Function
REQ-013 The prescaler counter SHALL count 0..SCAN_DIV-1 and wrap; scan_tick SHALL be high exactly in the cycle the counter equals SCAN_DIV-1.
REQ-014 pos SHALL increment modulo 8 in the cycle after scan_tick; frame_done SHALL assert in the scan_tick cycle when pos==7.
REQ-015 an SHALL equal ~(1<<pos), except when mode==1 and pos>=4, where it SHALL be 8'hFF (blanked); an SHALL be decoded from the registered pos and mode with zero added latency.
REQ-016 btn_mode SHALL pass a 2-flop synchronizer before any use.
REQ-017 Debounce FSM states are IDLE, CONFIRM_PRESS, HELD and CONFIRM_RELEASE.
REQ-018 IDLE->CONFIRM_PRESS on sync=1; CONFIRM_PRESS returns to IDLE if sync drops, else after DEB_CYCLES consecutive high cycles goes to HELD and emits a one-cycle internal press pulse.
REQ-019 HELD->CONFIRM_RELEASE on sync=0; CONFIRM_RELEASE returns to HELD if sync rises, else after DEB_CYCLES consecutive low cycles returns to IDLE; holding the button SHALL produce only one press.
REQ-020 A press SHALL set the pending flag and set the pending target to (pending ? target : mode)+1 mod 4, so multiple presses within one frame accumulate.
REQ-021 When auto_en=1, a frame counter SHALL count frame_done pulses; on the ROTATE_FRAMES-th pulse it SHALL request mode+1 mod 4 and clear.
REQ-022 A press SHALL clear the frame counter; a press and an auto request in the same cycle SHALL yield the press only (no double step).
REQ-023 auto_en=0 SHALL hold the frame counter at 0 and SHALL NOT discard a pending manual request.
REQ-024 A pending mode SHALL be applied only in the cycle after frame_done (together with pos going to 0), and the pending flag SHALL then clear; mode SHALL never change mid-frame.
REQ-025 A request arriving in the frame_done cycle itself SHALL be applied at the next frame boundary.

Reset
REQ-026 While rst_n=0 at a clock edge: mode=0, pos=0, an=8'hFE, scan_tick=0, frame_done=0, all counters 0, pending=0, debounce FSM=IDLE, synchronizer flops=0.
REQ-027 Reset asserted mid-frame or mid-debounce SHALL discard all in-progress state, with no press pulse emitted after release.

Structure
REQ-028 Mode encodings (MODE_LED, MODE_CNT, MODE_JMP, MODE_MEM) and the debounce state encoding SHALL live in a shared package, display_pkg.
REQ-029 Debounce SHALL be a sub-module btn_debounce (synchronizer + FSM, parameter DEB_CYCLES, output press pulse); the prescaler, scan and mode logic remain in display_sched.

Verification (SCAN_DIV=4, DEB_CYCLES=3, ROTATE_FRAMES=2)
REQ-030 Reset release, idle 40 cycles -> scan_tick every 4th cycle; pos 0..7 then 0; frame_done once per 32 cycles; an walks FE,FD,...,7F.
REQ-031 btn_mode high 2 cycles, then low -> no press, mode stays 0; btn high 10 cycles, then low 10 cycles -> exactly one mode increment, to 1, applied the cycle after the next frame_done.
REQ-032 mode=1 -> an=FF while pos is 4..7; FE..F7 while pos is 0..3.
REQ-033 auto_en=1, no presses -> mode steps 0->1->2->3->0, one step every 2 frames (64 cycles), each step coincident with pos=0.
REQ-034 Two debounced presses within one frame -> mode jumps 0->2 at a single boundary; a press coincident with the auto request -> exactly +1.
REQ-035 rst_n low for 1 cycle during CONFIRM_PRESS, with pending=1 and pos=5 -> all outputs at reset values next cycle; no mode change follows.
